// File: rtl/f2x_pkg.sv
// Shared widths, flag bundle and counter width for the float_to_fix arbiter slice.
package f2x_pkg;

    localparam int unsigned F2X_FLOAT_OP_WIDTH = 16;
    localparam int unsigned F2X_EXP_MSB_POS    = 14;
    localparam int unsigned F2X_EXP_LSB_POS    = 10;
    localparam int unsigned F2X_FIXED_OP_WIDTH = 40;
    localparam int unsigned F2X_NUM_REQ        = 4;
    localparam int unsigned F2X_EXC_CNT_W      = 16;

    typedef struct packed {
        logic nan;
        logic snan;
        logic inf;
    } f2x_flags_t;

    function automatic logic f2x_any_exc(input f2x_flags_t f);
        return f.nan | f.snan | f.inf;
    endfunction

endpackage

// File: rtl/float_to_fix_arbiter_if.sv
// Requester/result bus of float_to_fix_arbiter; counter ports exist only with F2X_ARB_EXC_CNT_EN.
interface float_to_fix_arbiter_if #(
    parameter int unsigned NUM_REQ        = f2x_pkg::F2X_NUM_REQ,
    parameter int unsigned FLOAT_OP_WIDTH = f2x_pkg::F2X_FLOAT_OP_WIDTH,
    parameter int unsigned FIXED_OP_WIDTH = f2x_pkg::F2X_FIXED_OP_WIDTH
);
    import f2x_pkg::*;

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                req_valid_i;
    logic [NUM_REQ-1:0]                req_ready_o;
    logic [NUM_REQ*FLOAT_OP_WIDTH-1:0] req_operand_i;
    logic                              res_valid_o;
    logic                              res_ready_i;
    logic [ID_W-1:0]                   res_id_o;
    logic [FIXED_OP_WIDTH-1:0]         res_value_o;
    logic                              res_nan_o;
    logic                              res_snan_o;
    logic                              res_inf_o;
`ifdef F2X_ARB_EXC_CNT_EN
    logic                              exc_clr_i;
    logic [NUM_REQ*F2X_EXC_CNT_W-1:0]  exc_cnt_o;
`endif

    modport slave (
        input  req_valid_i, req_operand_i, res_ready_i,
        output req_ready_o, res_valid_o, res_id_o, res_value_o,
               res_nan_o, res_snan_o, res_inf_o
`ifdef F2X_ARB_EXC_CNT_EN
        , input exc_clr_i, output exc_cnt_o
`endif
    );

    modport master (
        output req_valid_i, req_operand_i, res_ready_i,
        input  req_ready_o, res_valid_o, res_id_o, res_value_o,
               res_nan_o, res_snan_o, res_inf_o
`ifdef F2X_ARB_EXC_CNT_EN
        , output exc_clr_i, input exc_cnt_o
`endif
    );

endinterface

// File: rtl/f2x_rr_arb.sv
// Round-robin grant over N requests; the pointer moves only when the grant is taken.
module f2x_rr_arb #(
    parameter int unsigned N = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [N-1:0]         i_req,
    input  logic                 i_advance,
    output logic [N-1:0]         o_grant_c,
    output logic [$clog2(N)-1:0] o_grant_id_c,
    output logic                 o_grant_vld_c
);
    localparam int unsigned ID_W = $clog2(N);

    logic [ID_W-1:0] r_last;
    int unsigned     w_idx;

    // First asserted request at or after last+1, wrapping modulo N.
    always_comb begin
        o_grant_c     = '0;
        o_grant_id_c  = '0;
        o_grant_vld_c = 1'b0;
        w_idx         = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            w_idx = (32'(r_last) + off) % N;
            if (!o_grant_vld_c && i_req[ID_W'(w_idx)]) begin
                o_grant_vld_c               = 1'b1;
                o_grant_id_c                = ID_W'(w_idx);
                o_grant_c[ID_W'(w_idx)]     = 1'b1;
            end
        end
    end

    // Reset to N-1 so requester 0 has top priority.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_last <= ID_W'(N - 1);
        end else if (i_advance) begin
            r_last <= o_grant_id_c;
        end
    end

endmodule

// File: rtl/float_to_fix.sv
// Combinational float to two's-complement fixed-point converter with special-value flags.
module float_to_fix #(
    parameter int unsigned FLOAT_OP_WIDTH = f2x_pkg::F2X_FLOAT_OP_WIDTH,
    parameter int unsigned EXP_MSB_POS    = f2x_pkg::F2X_EXP_MSB_POS,
    parameter int unsigned EXP_LSB_POS    = f2x_pkg::F2X_EXP_LSB_POS,
    parameter int unsigned FIXED_OP_WIDTH = f2x_pkg::F2X_FIXED_OP_WIDTH
) (
    input  logic [FLOAT_OP_WIDTH-1:0] i_operand,
    output logic [FIXED_OP_WIDTH-1:0] o_value_c,
    output f2x_pkg::f2x_flags_t       o_flags_c
);
    import f2x_pkg::*;

    localparam int unsigned EXP_W  = EXP_MSB_POS - EXP_LSB_POS + 1;
    localparam int unsigned MANT_W = EXP_LSB_POS;

    logic                      w_sign;
    logic [EXP_W-1:0]          w_exp;
    logic [MANT_W-1:0]         w_mant;
    logic                      w_hidden;
    logic                      w_exp_max;
    logic [EXP_W-1:0]          w_shift;
    logic [FIXED_OP_WIDTH-1:0] w_mag;

    assign w_sign    = i_operand[FLOAT_OP_WIDTH-1];
    assign w_exp     = i_operand[EXP_MSB_POS:EXP_LSB_POS];
    assign w_mant    = i_operand[EXP_LSB_POS-1:0];
    assign w_hidden  = |w_exp;
    assign w_exp_max = &w_exp;

    // Denormals keep the significand unshifted; normals shift by exp-1.
    assign w_shift   = w_hidden ? (w_exp - EXP_W'(1)) : '0;
    assign w_mag     = FIXED_OP_WIDTH'({w_hidden, w_mant}) << w_shift;
    assign o_value_c = w_sign ? (~w_mag + FIXED_OP_WIDTH'(1)) : w_mag;

    assign o_flags_c.inf  = w_exp_max & ~(|w_mant);
    assign o_flags_c.nan  = w_exp_max & (|w_mant);
    assign o_flags_c.snan = w_exp_max & (|w_mant) & ~w_mant[MANT_W-1];

endmodule

// File: rtl/float_to_fix_arbiter.sv
// Shares one float_to_fix datapath among NUM_REQ requesters through a two-stage pipeline.
// Optional per-requester exception counters: define F2X_ARB_EXC_CNT_EN.
module float_to_fix_arbiter
    import f2x_pkg::*;
#(
    parameter int unsigned FLOAT_OP_WIDTH = F2X_FLOAT_OP_WIDTH,
    parameter int unsigned EXP_MSB_POS    = F2X_EXP_MSB_POS,
    parameter int unsigned EXP_LSB_POS    = F2X_EXP_LSB_POS,
    parameter int unsigned FIXED_OP_WIDTH = F2X_FIXED_OP_WIDTH,
    parameter int unsigned NUM_REQ        = F2X_NUM_REQ
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    float_to_fix_arbiter_if.slave  bus
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        w_grant;
    logic [ID_W-1:0]           w_grant_id;
    logic                      w_grant_vld;
    logic                      w_s1_free;
    logic                      w_s2_free;
    logic                      w_xfer;
    logic [FIXED_OP_WIDTH-1:0] w_cvt_value;
    f2x_flags_t                w_cvt_flags;

    logic                      r_s1_vld;
    logic [FLOAT_OP_WIDTH-1:0] r_s1_op;
    logic [ID_W-1:0]           r_s1_id;
    logic                      r_s2_vld;
    logic [FIXED_OP_WIDTH-1:0] r_s2_value;
    f2x_flags_t                r_s2_flags;
    logic [ID_W-1:0]           r_s2_id;

    assign w_s2_free       = ~r_s2_vld | bus.res_ready_i;
    assign w_s1_free       = ~r_s1_vld | w_s2_free;
    assign bus.req_ready_o = (rst_n_i && w_s1_free) ? w_grant : '0;
    assign w_xfer          = rst_n_i & w_s1_free & w_grant_vld;

    f2x_rr_arb #(.N(NUM_REQ)) u_arb (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .i_req         (bus.req_valid_i),
        .i_advance     (w_xfer),
        .o_grant_c     (w_grant),
        .o_grant_id_c  (w_grant_id),
        .o_grant_vld_c (w_grant_vld)
    );

    // S1: granted operand and its requester id.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_s1_vld <= 1'b0;
            r_s1_op  <= '0;
            r_s1_id  <= '0;
        end else if (w_xfer) begin
            r_s1_vld <= 1'b1;
            r_s1_op  <= bus.req_operand_i[w_grant_id*FLOAT_OP_WIDTH +: FLOAT_OP_WIDTH];
            r_s1_id  <= w_grant_id;
        end else if (w_s2_free) begin
            r_s1_vld <= 1'b0;
        end
    end

    float_to_fix #(
        .FLOAT_OP_WIDTH (FLOAT_OP_WIDTH),
        .EXP_MSB_POS    (EXP_MSB_POS),
        .EXP_LSB_POS    (EXP_LSB_POS),
        .FIXED_OP_WIDTH (FIXED_OP_WIDTH)
    ) u_cvt (
        .i_operand (r_s1_op),
        .o_value_c (w_cvt_value),
        .o_flags_c (w_cvt_flags)
    );

    // S2: converted result, drives the output port directly.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_s2_vld   <= 1'b0;
            r_s2_value <= '0;
            r_s2_flags <= '0;
            r_s2_id    <= '0;
        end else if (w_s2_free && r_s1_vld) begin
            r_s2_vld   <= 1'b1;
            r_s2_value <= w_cvt_value;
            r_s2_flags <= w_cvt_flags;
            r_s2_id    <= r_s1_id;
        end else if (bus.res_ready_i) begin
            r_s2_vld   <= 1'b0;
        end
    end

    assign bus.res_valid_o = r_s2_vld;
    assign bus.res_value_o = r_s2_value;
    assign bus.res_id_o    = r_s2_id;
    assign bus.res_nan_o   = r_s2_flags.nan;
    assign bus.res_snan_o  = r_s2_flags.snan;
    assign bus.res_inf_o   = r_s2_flags.inf;

`ifdef F2X_ARB_EXC_CNT_EN
    logic [F2X_EXC_CNT_W-1:0] r_exc_cnt [NUM_REQ];
    logic                     w_exc_hs;

    assign w_exc_hs = r_s2_vld & bus.res_ready_i & f2x_any_exc(r_s2_flags);

    // Saturating per-requester counts; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || bus.exc_clr_i) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_exc_cnt[i] <= '0;
            end
        end else if (w_exc_hs && (r_exc_cnt[r_s2_id] != '1)) begin
            r_exc_cnt[r_s2_id] <= r_exc_cnt[r_s2_id] + F2X_EXC_CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign bus.exc_cnt_o[g*F2X_EXC_CNT_W +: F2X_EXC_CNT_W] = r_exc_cnt[g];
    end
`endif

endmodule

// File: doc/float_to_fix_arbiter.md
# float_to_fix_arbiter

Shares one `float_to_fix` conversion datapath among `NUM_REQ` requesters. Each requester offers a floating-point operand over a valid/ready handshake. A round-robin arbiter grants one requester per cycle, and the converter sits between two pipeline registers. Results return on a single tagged valid/ready output port with full backpressure, at one result per cycle sustained throughput. The block sits between the producer lanes (e.g. per-channel sample sources) and the fixed-point accumulation datapath.

## Interface
- `FLOAT_OP_WIDTH`, 16: float operand width.
- `EXP_MSB_POS`, 14: exponent MSB position.
- `EXP_LSB_POS`, 10: exponent LSB position.
- `FIXED_OP_WIDTH`, 40: fixed-point result width.
- `NUM_REQ`, 4: number of requesters, ≥2. `ID_W = $clog2(NUM_REQ)` is a derived localparam.
- One clock; reset is synchronous and active-low. Ports are `clk_i` and `rst_n_i`.
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  synchronous active-low reset.
- `req_valid_i`  in  NUM_REQ  per-requester operand valid.
- `req_ready_o`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_operand_i`  in  NUM_REQ*FLOAT_OP_WIDTH  packed operands; requester i occupies slice i.
- `res_valid_o`  out  1  result valid.
- `res_ready_i`  in  1  consumer accept.
- `res_id_o`  out  ID_W  index of the originating requester.
- `res_value_o`  out  FIXED_OP_WIDTH  two's-complement fixed-point value.
- `res_nan_o`, `res_snan_o`, `res_inf_o`  out  1 each  converter flags.
- `exc_clr_i`  in  1  counter clear. Present only with `F2X_ARB_EXC_CNT_EN`.
- `exc_cnt_o`  out  NUM_REQ*16  per-requester exception counts. Present only with `F2X_ARB_EXC_CNT_EN`.

## Operation
- **Handshake.** A transfer occurs when valid and ready are both high at a rising edge.
  - A requester holds `req_valid_i` and its operand stable until accepted.
  - `req_valid_i` must not depend on `req_ready_o`.
- **Arbitration.** Round-robin over the asserted `req_valid_i` bits.
  - Search starts at `(last_granted+1) mod NUM_REQ`.
  - `req_ready_o[i] = grant[i] & s1_free`.
  - The pointer advances only on an actual transfer; a stalled grant does not rotate.
- **Stage S1.** Registers `{operand, id}` plus `s1_vld`. The operand feeds the combinational converter.
- **Stage S2.** Registers `{value, flags, id}` plus `s2_vld`. It drives the `res_*` outputs directly.
- **Pipeline advance rules.**
  - `s2_free = ~s2_vld | res_ready_i`.
  - `s1_free = ~s1_vld | s2_free`.
  - S1 loads when a grant transfers. Otherwise it clears when it advances into S2.
  - S2 loads from S1 when `s2_free & s1_vld`. Otherwise it clears on a `res_ready_i` handshake.
- **Conversion semantics.** Identical to `float_to_fix`:
  - Hidden bit is `|exp`.
  - Shift is `exp-1` for normal numbers, 0 for denormals.
  - Negation is two's complement when the sign bit is set.
  - Flags pass through unchanged; the block does not reinterpret them.
- **Data integrity.** No result is lost, duplicated or reordered. Output order equals grant order.
- **Outputs while invalid.** `res_value_o`, `res_id_o` and the flags hold their last value and are don't-care.

## Timing
- **Reset.** While `rst_n_i` is sampled low:
  - `s1_vld`, `s2_vld` = 0.
  - Round-robin pointer set so that requester 0 has highest priority.
  - `req_ready_o` = 0 and `res_valid_o` = 0.
  - `res_value_o`, `res_id_o` and all flags = 0.
  - Counters = 0.
- **Reset mid-operation.** In-flight results are discarded with no output handshake.
- **Latency.** A request accepted at edge k produces `res_valid_o` after edge k+1, i.e. 2 cycles from the handshake cycle when not stalled.
- **Throughput.** One transfer per cycle with `res_ready_i` held high.
- **Full pipe.** With S1 and S2 full and `res_ready_i` low, all `req_ready_o` are 0.
  - Raising `res_ready_i` makes `req_ready_o` available in that same cycle, because ready propagates combinationally through `s2_free`/`s1_free`.
- **Idle.** With no valid request, S1 empties and the pointer is unchanged.

## Configuration
- `F2X_ARB_EXC_CNT_EN` defined:
  - Adds `exc_clr_i`, `exc_cnt_o` and NUM_REQ 16-bit saturating counters.
  - Counter `[res_id_o]` increments on each output handshake with `res_nan_o|res_snan_o|res_inf_o`.
  - Counters saturate at 0xFFFF.
  - `exc_clr_i` zeroes all counters and wins over a simultaneous increment.
- `F2X_ARB_EXC_CNT_EN` undefined: the ports and counters are absent, and the datapath behaviour is identical.

## Structure
- Package `f2x_pkg` holds:
  - Half-precision default widths and positions.
  - Typedef `f2x_flags_t` (`nan`, `snan`, `inf`).
  - Counter width constant `F2X_EXC_CNT_W = 16`.
- Sub-module: instantiate the existing `float_to_fix` between S1 and S2.
- The round-robin grant logic is a small internal `f2x_rr_arb` sub-module, reusable elsewhere.

## Test plan
- **Reset.** Hold `rst_n_i` low 3 cycles with all `req_valid_i`=4'hF → `req_ready_o`=0, `res_valid_o`=0, all outputs 0. After release, the first grant goes to requester 0.
- **Single request.** Requester 2 sends 0x3C00, `res_ready_i`=1 → `res_valid_o` two cycles after the handshake, `res_id_o`=2, `res_value_o`=40'h0001000000, flags 0.
- **Fairness.** All four requesters continuously valid, `res_ready_i`=1 → one result per cycle, ids 0,1,2,3,0,1… with no gaps.
- **Backpressure.** Streaming requests with `res_ready_i` low for 5 cycles → S2 holds its value and S1 fills. `req_ready_o`=0 during the stall. On release, results resume in grant order with no loss or duplication.
- **Sign and special values.**
  - 0xBC00 → 40'hFFFF000000.
  - 0x7C00 → `res_inf_o`=1.
  - 0x7E00 → `res_nan_o`=1.
  - 0x7C01 → `res_snan_o`=1.
- **Exception counters** (`F2X_ARB_EXC_CNT_EN`).
  - Requester 1 sends 0x7C00 three times → `exc_cnt_o[1]`=3; the other counters stay 0.
  - `exc_clr_i` pulsed in the cycle of a fourth exception handshake → counter reads 0.
